// File: rtl/axi4_master_ctrl.sv
// axi4_master_ctrl
// AXI4 initiator that converts a command/data stream into AXI4 write (AW/W/B)
// and read (AR/R) transactions. One transaction is in flight at a time and
// INCR bursts of 1..256 beats are supported.
//
// Ports
//   ACLK, ARESETn           clock (rising edge), asynchronous active-low reset
//   cmd_*                   command handshake: write/read, id, address, beats-1
//   wr_data/valid/ready     write data stream, passed through to the W channel
//   rd_data/valid/last/ready read data stream, passed through from the R channel
//   rsp_*                   one-cycle completion pulse with id and response
//   M_AW*, M_W*, M_B*       AXI4 write address, write data, write response
//   M_AR*, M_R*             AXI4 read address, read data
module axi4_master_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    // command
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ID_WIDTH-1:0]     cmd_id,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    // write data stream
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    // read data stream
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    rd_last,
    input  logic                    rd_ready,
    // completion
    output logic                    rsp_valid,
    output logic                    rsp_write,
    output logic [ID_WIDTH-1:0]     rsp_id,
    output logic [1:0]              rsp_resp,
    // AXI write address
    output logic [ID_WIDTH-1:0]     M_AWID,
    output logic [ADDR_WIDTH-1:0]   M_AWADDR,
    output logic [LEN_WIDTH-1:0]    M_AWLEN,
    output logic [2:0]              M_AWSIZE,
    output logic [1:0]              M_AWBURST,
    output logic                    M_AWLOCK,
    output logic [3:0]              M_AWCACHE,
    output logic [2:0]              M_AWPROT,
    output logic [3:0]              M_AWQOS,
    output logic                    M_AWVALID,
    input  logic                    M_AWREADY,
    // AXI write data
    output logic [DATA_WIDTH-1:0]   M_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_WSTRB,
    output logic                    M_WLAST,
    output logic                    M_WVALID,
    input  logic                    M_WREADY,
    // AXI write response
    input  logic [ID_WIDTH-1:0]     M_BID,
    input  logic [1:0]              M_BRESP,
    input  logic                    M_BVALID,
    output logic                    M_BREADY,
    // AXI read address
    output logic [ID_WIDTH-1:0]     M_ARID,
    output logic [ADDR_WIDTH-1:0]   M_ARADDR,
    output logic [LEN_WIDTH-1:0]    M_ARLEN,
    output logic [2:0]              M_ARSIZE,
    output logic [1:0]              M_ARBURST,
    output logic                    M_ARLOCK,
    output logic [3:0]              M_ARCACHE,
    output logic [2:0]              M_ARPROT,
    output logic [3:0]              M_ARQOS,
    output logic                    M_ARVALID,
    input  logic                    M_ARREADY,
    // AXI read data
    input  logic [ID_WIDTH-1:0]     M_RID,
    input  logic [DATA_WIDTH-1:0]   M_RDATA,
    input  logic [1:0]              M_RRESP,
    input  logic                    M_RLAST,
    input  logic                    M_RVALID,
    output logic                    M_RREADY
);

    localparam logic [2:0] AXSIZE      = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, RSP} state_t;

    state_t                  state_q, state_d;
    logic                    alive_q;     // low only until the first edge after reset release
    logic                    write_q;
    logic [ID_WIDTH-1:0]     id_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    beat_q;
    logic [1:0]              resp_q;
    logic [2:0]              size_q;
    logic [1:0]              burst_q;
    logic                    aw_valid_q;
    logic                    ar_valid_q;

    logic cmd_hs, aw_hs, ar_hs, w_hs, r_hs, b_hs;
    logic r_proto_err;
    logic [1:0] r_beat_resp;

    // ---------------- stream / channel pass-through ----------------
    assign cmd_ready = (state_q == IDLE) && alive_q;

    assign M_WVALID  = (state_q == W) && wr_valid;
    assign wr_ready  = (state_q == W) && M_WREADY;
    assign M_WDATA   = wr_data;
    assign M_WSTRB   = (state_q == W) ? '1 : '0;
    assign M_WLAST   = (state_q == W) && (beat_q == len_q);

    assign M_BREADY  = (state_q == B);

    assign rd_valid  = (state_q == R) && M_RVALID;
    assign M_RREADY  = (state_q == R) && rd_ready;
    assign rd_data   = M_RDATA;
    assign rd_last   = (state_q == R) && M_RLAST;

    assign rsp_valid = (state_q == RSP);
    assign rsp_write = rsp_valid && write_q;
    assign rsp_id    = rsp_valid ? id_q : '0;
    assign rsp_resp  = rsp_valid ? resp_q : RESP_OKAY;

    // Address channels share the latched command fields; VALID qualifies them.
    assign M_AWID    = id_q;
    assign M_AWADDR  = addr_q;
    assign M_AWLEN   = len_q;
    assign M_AWSIZE  = size_q;
    assign M_AWBURST = burst_q;
    assign M_AWLOCK  = 1'b0;
    assign M_AWCACHE = 4'd0;
    assign M_AWPROT  = 3'd0;
    assign M_AWQOS   = 4'd0;
    assign M_AWVALID = aw_valid_q;

    assign M_ARID    = id_q;
    assign M_ARADDR  = addr_q;
    assign M_ARLEN   = len_q;
    assign M_ARSIZE  = size_q;
    assign M_ARBURST = burst_q;
    assign M_ARLOCK  = 1'b0;
    assign M_ARCACHE = 4'd0;
    assign M_ARPROT  = 3'd0;
    assign M_ARQOS   = 4'd0;
    assign M_ARVALID = ar_valid_q;

    // ---------------- handshakes and read status ----------------
    assign cmd_hs = cmd_valid && cmd_ready;
    assign aw_hs  = aw_valid_q && M_AWREADY;
    assign ar_hs  = ar_valid_q && M_ARREADY;
    assign w_hs   = M_WVALID && M_WREADY;
    assign b_hs   = M_BREADY && M_BVALID;
    assign r_hs   = rd_valid && rd_ready;

    // A beat is malformed if its ID is foreign or RLAST disagrees with the
    // expected last index (early RLAST, or a missing RLAST at index len).
    assign r_proto_err = (M_RID != id_q) || (M_RLAST != (beat_q == len_q));
    assign r_beat_resp = r_proto_err ? RESP_SLVERR : M_RRESP;

    // ---------------- next state ----------------
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_hs) state_d = cmd_write ? AW : AR;
            AW:      if (aw_hs) state_d = W;
            W:       if (w_hs && M_WLAST) state_d = B;
            B:       if (b_hs) state_d = RSP;
            AR:      if (ar_hs) state_d = R;
            R:       if (r_hs && M_RLAST) state_d = RSP;
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- registers ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= IDLE;
            alive_q    <= 1'b0;
            write_q    <= 1'b0;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            resp_q     <= RESP_OKAY;
            size_q     <= 3'd0;
            burst_q    <= 2'd0;
            aw_valid_q <= 1'b0;
            ar_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            alive_q    <= 1'b1;
            aw_valid_q <= (state_d == AW);
            ar_valid_q <= (state_d == AR);

            if (cmd_hs) begin
                write_q <= cmd_write;
                id_q    <= cmd_id;
                addr_q  <= cmd_addr;
                len_q   <= cmd_len;
                resp_q  <= RESP_OKAY;
                size_q  <= AXSIZE;
                burst_q <= BURST_INCR;
            end

            // Beat index restarts on each data phase and saturates so an
            // overlong read burst cannot wrap back to a "valid" index.
            if (aw_hs || ar_hs) begin
                beat_q <= '0;
            end else if (w_hs || r_hs) begin
                beat_q <= (beat_q == '1) ? beat_q : beat_q + 1'b1;
            end

            if (b_hs) begin
                resp_q <= (M_BID != id_q) ? RESP_SLVERR : M_BRESP;
            end

            // Only the first non-OKAY beat status is kept.
            if (r_hs && (resp_q == RESP_OKAY)) begin
                resp_q <= r_beat_resp;
            end
        end
    end

endmodule

// File: tb/tb_axi4_master_ctrl.sv
// Self-checking bench for axi4_master_ctrl. A behavioural AXI slave with its
// own memory answers the DUT; a separate reference memory, updated only from
// completed write commands, supplies the expected read data.
module tb_axi4_master_ctrl;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_id;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, rd_last, rd_ready;
    logic        rsp_valid, rsp_write;
    logic [3:0]  rsp_id;
    logic [1:0]  rsp_resp;
    logic [3:0]  M_AWID, M_AWCACHE, M_AWQOS;
    logic [31:0] M_AWADDR;
    logic [7:0]  M_AWLEN;
    logic [2:0]  M_AWSIZE, M_AWPROT;
    logic [1:0]  M_AWBURST;
    logic        M_AWLOCK, M_AWVALID, M_AWREADY;
    logic [31:0] M_WDATA;
    logic [3:0]  M_WSTRB;
    logic        M_WLAST, M_WVALID, M_WREADY;
    logic [3:0]  M_BID;
    logic [1:0]  M_BRESP;
    logic        M_BVALID, M_BREADY;
    logic [3:0]  M_ARID, M_ARCACHE, M_ARQOS;
    logic [31:0] M_ARADDR;
    logic [7:0]  M_ARLEN;
    logic [2:0]  M_ARSIZE, M_ARPROT;
    logic [1:0]  M_ARBURST;
    logic        M_ARLOCK, M_ARVALID, M_ARREADY;
    logic [3:0]  M_RID;
    logic [31:0] M_RDATA;
    logic [1:0]  M_RRESP;
    logic        M_RLAST, M_RVALID, M_RREADY;

    axi4_master_ctrl dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_id(rsp_id), .rsp_resp(rsp_resp),
        .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE),
        .M_AWBURST(M_AWBURST), .M_AWLOCK(M_AWLOCK), .M_AWCACHE(M_AWCACHE), .M_AWPROT(M_AWPROT),
        .M_AWQOS(M_AWQOS), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST), .M_WVALID(M_WVALID),
        .M_WREADY(M_WREADY),
        .M_BID(M_BID), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
        .M_ARBURST(M_ARBURST), .M_ARLOCK(M_ARLOCK), .M_ARCACHE(M_ARCACHE), .M_ARPROT(M_ARPROT),
        .M_ARQOS(M_ARQOS), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
        .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] slv_mem [0:1023];   // slave storage, written by DUT W beats
    logic [31:0] ref_mem [0:1023];   // expected contents, written from commands
    logic [31:0] wbuf    [0:255];    // data offered on the write stream

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic coin();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
        M_AWREADY = 1'b0; M_WREADY = 1'b0; M_BID = '0; M_BRESP = '0; M_BVALID = 1'b0;
        M_ARREADY = 1'b0; M_RID = '0; M_RDATA = '0; M_RRESP = '0; M_RLAST = 1'b0; M_RVALID = 1'b0;
    endtask

    task automatic fill_wbuf();
        for (int i = 0; i < 256; i++) wbuf[i] = $urandom;
    endtask

    // One full transaction. mode: 0 random handshakes, 1 zero-wait slave and
    // always-ready streams, 2 zero-wait slave with wr_valid toggling.
    // Inputs are driven at the falling edge; outputs are sampled 1 time unit
    // later, so each observed handshake completes at the next rising edge.
    task automatic run_txn(input bit wr, input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input int mode, input int aw_hold,
                           input logic [1:0] bresp_inj, input bit bid_bad,
                           input int early_last, input int abort_w,
                           output int lat, output int wcount);
        int cyc = 0;
        int c0 = -1;
        int hold = 0;
        int wbeat = 0;
        int rbeat = 0;
        bit cmd_done = 0, ax_done = 0, w_done = 0, b_done = 0, r_done = 0;
        bit got_rsp = 0, aborted = 0, bv = 0, rv = 0;
        int idx = int'(addr >> 2);
        int last_beat = (early_last >= 0) ? early_last : int'(len);
        logic [1:0] exp_resp;
        lat = -1;
        if (wr) exp_resp = bid_bad ? 2'b10 : bresp_inj;
        else    exp_resp = (last_beat != int'(len)) ? 2'b10 : 2'b00;

        while (!got_rsp && !aborted && cyc < 6000) begin
            @(negedge ACLK);
            cmd_valid = !cmd_done; cmd_write = wr; cmd_id = id; cmd_addr = addr; cmd_len = len;
            M_AWREADY = (hold >= aw_hold) && (mode != 0 || coin());
            M_ARREADY = (hold >= aw_hold) && (mode != 0 || coin());
            wr_valid  = (mode == 1) ? 1'b1 : (mode == 2) ? 1'((cyc % 2) == 1) : coin();
            wr_data   = wbuf[wbeat % 256];
            M_WREADY  = (mode != 0) || coin();
            if (wr && w_done && ax_done && !b_done) bv = (mode != 0) || bv || coin();
            else bv = 1'b0;
            M_BVALID = bv; M_BID = bid_bad ? ~id : id; M_BRESP = bresp_inj;
            if (!wr && ax_done && !r_done) rv = (mode != 0) || rv || coin();
            else rv = 1'b0;
            M_RVALID = rv; M_RID = id; M_RRESP = 2'b00;
            M_RDATA  = slv_mem[(idx + rbeat) % 1024];
            M_RLAST  = (rbeat == last_beat);
            rd_ready = (mode != 0) || coin();
            #1;

            if (cmd_valid && cmd_ready) begin
                cmd_done = 1; c0 = cyc;
            end else if (cmd_done) begin
                check("cmd_ready_busy", 64'(cmd_ready), 64'(0));
            end

            if (wr) begin
                check("ar_quiet", 64'(M_ARVALID), 64'(0));
                check("w_gate", 64'(M_WVALID), 64'(ax_done && !w_done && wr_valid));
                check("wready_pass", 64'(wr_ready), 64'(ax_done && !w_done && M_WREADY));
                if (M_WVALID && M_WREADY) begin
                    check("wdata", 64'(M_WDATA), 64'(wbuf[wbeat % 256]));
                    check("wstrb", 64'(M_WSTRB), 64'(4'hF));
                    check("wlast", 64'(M_WLAST), 64'(wbeat == int'(len)));
                    slv_mem[(idx + wbeat) % 1024] = M_WDATA;
                    wbeat++;
                    if (M_WLAST) w_done = 1;
                    if (abort_w > 0 && wbeat == abort_w) aborted = 1;
                end
                check("awvalid", 64'(M_AWVALID), 64'(cmd_done && c0 != cyc && !ax_done));
                if (M_AWVALID) begin
                    check("awaddr", 64'(M_AWADDR), 64'(addr));
                    check("awlen", 64'(M_AWLEN), 64'(len));
                    check("awid", 64'(M_AWID), 64'(id));
                    check("awsize", 64'(M_AWSIZE), 64'(3'd2));
                    check("awburst", 64'(M_AWBURST), 64'(2'b01));
                    check("awattr", 64'({M_AWLOCK, M_AWCACHE, M_AWPROT, M_AWQOS}), 64'(0));
                    if (M_AWREADY) ax_done = 1; else hold++;
                end
                if (M_BVALID) check("bready", 64'(M_BREADY), 64'(1));
                if (M_BVALID && M_BREADY) b_done = 1;
            end else begin
                check("aw_quiet", 64'(M_AWVALID), 64'(0));
                check("w_quiet", 64'(M_WVALID), 64'(0));
                check("rd_valid", 64'(rd_valid), 64'(M_RVALID));
                check("rready_pass", 64'(M_RREADY), 64'(ax_done && !r_done && rd_ready));
                if (rd_valid && rd_ready) begin
                    check("rdata", 64'(rd_data), 64'(ref_mem[(idx + rbeat) % 1024]));
                    check("rd_last", 64'(rd_last), 64'(rbeat == last_beat));
                    rbeat++;
                    if (rbeat == last_beat + 1) r_done = 1;
                end
                check("arvalid", 64'(M_ARVALID), 64'(cmd_done && c0 != cyc && !ax_done));
                if (M_ARVALID) begin
                    check("araddr", 64'(M_ARADDR), 64'(addr));
                    check("arlen", 64'(M_ARLEN), 64'(len));
                    check("arid", 64'(M_ARID), 64'(id));
                    check("arsize", 64'(M_ARSIZE), 64'(3'd2));
                    check("arburst", 64'(M_ARBURST), 64'(2'b01));
                    check("arattr", 64'({M_ARLOCK, M_ARCACHE, M_ARPROT, M_ARQOS}), 64'(0));
                    if (M_ARREADY) ax_done = 1; else hold++;
                end
            end

            if (rsp_valid) begin
                check("rsp_after_done", 64'(wr ? b_done : r_done), 64'(1));
                check("rsp_write", 64'(rsp_write), 64'(wr));
                check("rsp_id", 64'(rsp_id), 64'(id));
                check("rsp_resp", 64'(rsp_resp), 64'(exp_resp));
                check("cmd_ready_in_rsp", 64'(cmd_ready), 64'(0));
                got_rsp = 1;
                lat = cyc - c0;
            end
            cyc++;
        end

        wcount = wbeat;
        if (!aborted) begin
            check("txn_completed", 64'(got_rsp), 64'(1));
            if (aw_hold > 0) check("ax_hold_cycles", 64'(hold), 64'(aw_hold));
            @(negedge ACLK);
            idle_inputs();
            #1;
            check("rsp_one_cycle", 64'(rsp_valid), 64'(0));
            if (got_rsp) check("cmd_ready_back", 64'(cmd_ready), 64'(1));
            if (wr && got_rsp) begin
                for (int i = 0; i <= int'(len); i++) ref_mem[(idx + i) % 1024] = wbuf[i];
            end
        end
    endtask

    initial begin
        int lat, wc;
        idle_inputs();
        for (int i = 0; i < 1024; i++) begin
            slv_mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0003);
            ref_mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0003);
        end

        // Reset state
        repeat (3) @(negedge ACLK);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        check("rst_valids", 64'({M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rd_valid, wr_ready}), 64'(0));
        check("rst_rsp", 64'({rsp_valid, rsp_write, rsp_id, rsp_resp}), 64'(0));
        check("rst_fields", 64'({M_AWADDR, M_AWLEN, M_AWID, M_AWSIZE, M_AWBURST}), 64'(0));
        ARESETn = 1'b1;
        @(negedge ACLK);
        #1;
        check("cmd_ready_after_reset", 64'(cmd_ready), 64'(1));

        // Single-beat write, zero-wait slave
        fill_wbuf();
        wbuf[0] = 32'hABCD_0123;
        run_txn(1'b1, 4'd2, 32'h4, 8'd0, 1, 0, 2'b00, 1'b0, -1, 0, lat, wc);
        check("wr_latency", 64'(lat), 64'(4));
        check("slave_mem1", 64'(slv_mem[1]), 64'(32'hABCD_0123));

        // Single-beat read of the same word
        run_txn(1'b0, 4'd4, 32'h4, 8'd0, 1, 0, 2'b00, 1'b0, -1, 0, lat, wc);
        check("rd_latency", 64'(lat), 64'(3));

        // Len-3 burst with wr_valid toggling, then read back
        fill_wbuf();
        run_txn(1'b1, 4'd3, 32'h10, 8'd3, 2, 0, 2'b00, 1'b0, -1, 0, lat, wc);
        check("toggle_w_beats", 64'(wc), 64'(4));
        run_txn(1'b0, 4'd5, 32'h10, 8'd3, 0, 0, 2'b00, 1'b0, -1, 0, lat, wc);

        // AWREADY held low 5 cycles, then throttled read-back
        fill_wbuf();
        run_txn(1'b1, 4'd6, 32'h200, 8'd2, 1, 5, 2'b00, 1'b0, -1, 0, lat, wc);
        run_txn(1'b0, 4'd6, 32'h200, 8'd7, 0, 0, 2'b00, 1'b0, -1, 0, lat, wc);

        // Error responses
        fill_wbuf();
        run_txn(1'b1, 4'd7, 32'h300, 8'd1, 0, 0, 2'b10, 1'b0, -1, 0, lat, wc);
        run_txn(1'b1, 4'd8, 32'h340, 8'd0, 0, 0, 2'b00, 1'b1, -1, 0, lat, wc);
        run_txn(1'b0, 4'd9, 32'h300, 8'd3, 0, 0, 2'b00, 1'b0, 1, 0, lat, wc);

        // Unaligned address passes through; maximum-length read
        run_txn(1'b0, 4'd1, 32'h102, 8'd1, 0, 0, 2'b00, 1'b0, -1, 0, lat, wc);
        run_txn(1'b0, 4'd3, 32'h0, 8'd255, 0, 0, 2'b00, 1'b0, -1, 0, lat, wc);

        // Reset in the middle of a W burst
        fill_wbuf();
        run_txn(1'b1, 4'd10, 32'hF00, 8'd7, 1, 0, 2'b00, 1'b0, -1, 2, lat, wc);
        @(negedge ACLK);
        wr_valid = 1'b1; M_WREADY = 1'b0;
        #1;
        check("wvalid_before_reset", 64'(M_WVALID), 64'(1));
        ARESETn = 1'b0;
        #1;
        check("mid_reset_valids", 64'({M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rd_valid, wr_ready}), 64'(0));
        check("mid_reset_cmd_rsp", 64'({cmd_ready, rsp_valid}), 64'(0));
        repeat (2) @(negedge ACLK);
        idle_inputs();
        ARESETn = 1'b1;
        @(negedge ACLK);
        #1;
        check("cmd_ready_after_abort", 64'(cmd_ready), 64'(1));
        fill_wbuf();
        run_txn(1'b1, 4'd11, 32'h40, 8'd2, 0, 0, 2'b00, 1'b0, -1, 0, lat, wc);
        run_txn(1'b0, 4'd12, 32'h40, 8'd2, 0, 0, 2'b00, 1'b0, -1, 0, lat, wc);

        // Randomized traffic
        for (int t = 0; t < 24; t++) begin
            logic [7:0] len;
            logic [31:0] addr;
            len  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 3));
            addr = 32'($urandom_range(0, 700)) << 2;
            fill_wbuf();
            run_txn(coin(), 4'($urandom_range(0, 15)), addr, len, 0, 0, 2'b00, 1'b0, -1, 0, lat, wc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi4_master_ctrl.md
# axi4_master_ctrl

AXI4 initiator that turns a simple command/data stream interface into complete AXI4 write (AW/W/B) and read (AR/R) transactions toward the `axi4_dut` memory slave. It sits between on-chip logic and the slave's `MEM_*` port set. It replaces hand-driven bench stimulus with synthesizable, protocol-correct handshaking. One transaction is outstanding at a time; INCR bursts of 1–256 beats are supported.

## Interface
- `DATA_WIDTH`, 32, data bus width (power of 2, ≥8)
- `ADDR_WIDTH`, 32, address width
- `ID_WIDTH`, 4, AXI ID width
- `LEN_WIDTH`, 8, burst length field width

- `ACLK` in 1: clock, all logic on rising edge
- `ARESETn` in 1: asynchronous, active-low reset
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake
- `cmd_write` in 1: 1 = write, 0 = read
- `cmd_id` in ID_WIDTH, `cmd_addr` in ADDR_WIDTH, `cmd_len` in LEN_WIDTH: ID, start address, beats−1
- `wr_data` in DATA_WIDTH, `wr_valid` in 1, `wr_ready` out 1: write data stream
- `rd_data` out DATA_WIDTH, `rd_valid` out 1, `rd_last` out 1, `rd_ready` in 1: read data stream
- `rsp_valid` out 1, `rsp_write` out 1, `rsp_id` out ID_WIDTH, `rsp_resp` out 2: completion pulse
- `M_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWLOCK/AWCACHE/AWPROT/AWQOS/AWVALID` out, `M_AWREADY` in
- `M_WDATA/WSTRB/WLAST/WVALID` out, `M_WREADY` in
- `M_BID/BRESP/BVALID` in, `M_BREADY` out
- `M_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT/ARQOS/ARVALID` out, `M_ARREADY` in
- `M_RID/RDATA/RRESP/RLAST/RVALID` in, `M_RREADY` out

## Operation
- FSM states: IDLE, AW, W, B, AR, R, RSP.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch cmd fields and go to AW (write) or AR (read).
- AW/AR: the registered AxVALID stays high with stable fields until AxREADY. On the handshake, go to W or R.
- AxSIZE = log2(DATA_WIDTH/8) (3'b010 at 32 bits). AxBURST = 2'b01 INCR. LOCK/CACHE/PROT/QOS = 0.
- Address is passed unmodified, including unaligned low bits.
- W: `M_WVALID` = `wr_valid`, `wr_ready` = `M_WREADY`, `M_WDATA` = `wr_data`, WSTRB all ones. Data passes through combinationally.
- W beat counter: 8-bit, cleared on entry, +1 per W handshake. `M_WLAST` = (count == latched len). The handshake with WLAST moves the FSM to B.
- B: `M_BREADY`=1. On BVALID, capture BRESP. If BID ≠ latched ID, force resp = 2'b10. Go to RSP.
- R: `rd_valid` = `M_RVALID`, `M_RREADY` = `rd_ready`, `rd_data` = `M_RDATA`, `rd_last` = `M_RLAST`.
- R status: capture the first non-OKAY RRESP. RID mismatch, or RLAST at a beat index ≠ len, records SLVERR (2'b10). The handshake with RLAST moves the FSM to RSP.
- If beat count reaches len without RLAST, continue accepting beats until RLAST. Counter saturates at 255; resp = SLVERR.
- RSP: `rsp_valid`=1 for exactly one cycle with `rsp_write`, `rsp_id`, `rsp_resp`. Then IDLE. There is no backpressure on rsp.

## Timing
- Reset values: all VALID/READY outputs 0, `rsp_*` 0, `cmd_ready` 0 during reset, all address/control fields 0. FSM returns to IDLE.
- Reset asserted mid-transaction drops every VALID asynchronously. No recovery of the partial burst.
- `cmd_ready` is high the first cycle after reset release.
- Command accepted at edge N → AxVALID high from N+1. Minimum AxVALID pulse is 1 cycle if AxREADY is already high.
- W beats start the cycle after the AW handshake. AW and W never overlap.
- Single-beat write, zero-wait slave: cmd edge N, AW hs N+1, W hs N+2, B hs N+3, `rsp_valid` in cycle N+4, `cmd_ready` again at N+5.
- Single-beat read, zero-wait slave: AR hs N+1, R hs at the slave's first RVALID, `rsp_valid` the following cycle.
- `cmd_valid` during non-IDLE is ignored (`cmd_ready`=0). A simultaneous `cmd_valid` and `rsp_valid` cycle is not accepted.

## Test plan
- Write id 2, addr 0x4, len 0, data 0xABCD0123 → AWADDR 0x4, AWLEN 0, WLAST on the sole beat, `rsp_valid` with resp 0, id 2; slave mem[1] = 0xABCD0123.
- Read id 4, addr 0x4, len 0 after the above → `rd_data` 0xABCD0123, `rd_last`=1, rsp id 4, resp 0, `rsp_write`=0.
- Write burst len 3 at 0x10 with `wr_valid` toggling every other cycle → exactly 4 W handshakes, WLAST only on the 4th; readback gives the 4 words in order.
- Slave holds AWREADY low 5 cycles, then RREADY is throttled by `rd_ready` → AWVALID/fields stable for all 5 cycles; no R beat lost.
- Slave returns BRESP 2'b10, or RLAST on beat 1 of a len-3 read → `rsp_resp` = 2'b10.
- Assert ARESETn low during a W burst → all VALIDs 0 immediately; after release, `cmd_ready`=1 and a new write completes normally.
